// File: rtl/ricosoc_boot_pkg.sv
// Shared definitions for the boot ROM copier: FSM state encoding and
// native-memory write-port constants.
package ricosoc_boot_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } boot_state_e;

    localparam logic [3:0]  WSTRB_FULL        = 4'hF;
    localparam logic [31:0] DEFAULT_DEST_BASE = 32'h0000_0000;

endpackage

// File: rtl/boot_watchdog.sv
// Saturating wait counter for one RAM write; expired is high once the count
// reaches TIMEOUT_CYCLES-1.
module boot_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int           WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    // NOTE: next-state is given a default before any branch so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/rom_boot_copier.sv
// Copies COPY_WORDS words from the boot ROM into RAM over a picorv32-style
// write port, holding the CPU in reset until the copy completes.
module rom_boot_copier
    import ricosoc_boot_pkg::*;
#(
    parameter int          RAM_DATA_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH = 8,
    parameter int          SRC_BASE       = 0,
    parameter int          COPY_WORDS     = 256,
    parameter logic [31:0] DEST_BASE      = DEFAULT_DEST_BASE,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart,
    output logic [RAM_ADDR_WIDTH-1:0] rom_raddr,
    input  logic [RAM_DATA_WIDTH-1:0] rom_rdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    output logic                      cpu_resetn,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int                        IDX_W      = $clog2(COPY_WORDS) + 1;
    localparam logic [IDX_W-1:0]          LAST_IDX   = IDX_W'(COPY_WORDS - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] SRC_BASE_A = RAM_ADDR_WIDTH'(SRC_BASE);

    boot_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wd_clr, wd_en, wd_expired;

    boot_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WRITE;
            S_WRITE: begin
                // An acknowledge on the expiry cycle still completes the word.
                if (mem_ready) begin
                    wd_clr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end else begin
                    wd_en = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    idx_d   = '0;
                    wd_clr  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // rom_raddr is a function of idx only, so it holds through WRITE and
    // keeps the ROM's registered output stable for the whole request.
    always_comb begin
        rom_raddr  = SRC_BASE_A + RAM_ADDR_WIDTH'(idx_q);
        mem_addr   = DEST_BASE + (32'(idx_q) << 2);
        mem_valid  = (state_q == S_WRITE);
        mem_wstrb  = (state_q == S_WRITE) ? WSTRB_FULL : 4'h0;
        mem_wdata  = (state_q == S_WRITE) ? 32'(rom_rdata) : 32'h0;
        busy       = (state_q == S_FETCH) || (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        cpu_resetn = (state_q == S_DONE);
        error      = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_rom_boot_copier.sv
// Self-checking bench for rom_boot_copier: random ROM image and ready delays
// compared against an address/data sequence computed from the copy rules.
module tb_rom_boot_copier;

    localparam int          AW    = 8;
    localparam int          SRC   = 254;
    localparam int          NW    = 4;
    localparam logic [31:0] DBASE = 32'hFFFF_FFF8;
    localparam int          TMO   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          restart = 1'b0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] rom_raddr;
    logic [31:0]   rom_rdata;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          cpu_resetn, busy, done, error;

    logic [31:0] rom_mem [256];
    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    rom_boot_copier #(
        .RAM_DATA_WIDTH(32),
        .RAM_ADDR_WIDTH(AW),
        .SRC_BASE      (SRC),
        .COPY_WORDS    (NW),
        .DEST_BASE     (DBASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .rom_raddr (rom_raddr),
        .rom_rdata (rom_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .cpu_resetn(cpu_resetn),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Boot ROM: synchronous read, one cycle of latency.
    always @(posedge clk) begin
        rom_rdata <= rom_mem[rom_raddr];
        cyc       <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model of the copy: word k goes from ROM (SRC+k) mod 256 to DBASE+4k.
    function automatic logic [AW-1:0] exp_raddr(input int k);
        return AW'((SRC + k) % 256);
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        return DBASE + 32'(4 * k);
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        return rom_mem[exp_raddr(k)];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    endtask

    task automatic snapshot(output logic [31:0] got [9]);
        got = '{32'(rom_raddr), 32'(mem_valid), mem_addr, mem_wdata, 32'(mem_wstrb),
                32'(cpu_resetn), 32'(busy), 32'(done), 32'(error)};
    endtask

    // Drives one full copy; dly[k] is the number of WRITE cycles before ack of word k.
    task automatic copy_words(input int dly [NW], input int restart_at, input string tag);
        for (int k = 0; k < NW; k++) begin
            int guard = 0;
            while (mem_valid !== 1'b1 && guard < 4) begin
                step();
                guard++;
            end
            total_cnt++;
            if (mem_valid !== 1'b1) begin
                $display("FAIL %s_valid_wait word %0d: mem_valid=%b required 1", tag, k, mem_valid);
                return;
            end
            pass_cnt++;
            for (int w = 0; w <= dly[k]; w++) begin
                total_cnt++;
                if (mem_valid !== 1'b1 || mem_addr !== exp_addr(k) || mem_wdata !== exp_data(k) ||
                    mem_wstrb !== 4'hF || rom_raddr !== exp_raddr(k) || busy !== 1'b1 ||
                    cpu_resetn !== 1'b0 || done !== 1'b0) begin
                    $display("FAIL %s_write word %0d cyc %0d: valid=%b addr=%h data=%h strb=%h raddr=%0d busy=%b rstn=%b done=%b required 1 %h %h f %0d 1 0 0",
                             tag, k, w, mem_valid, mem_addr, mem_wdata, mem_wstrb, rom_raddr,
                             busy, cpu_resetn, done, exp_addr(k), exp_data(k), exp_raddr(k));
                end else begin
                    pass_cnt++;
                end
                mem_ready = (w == dly[k]);
                restart   = (k == restart_at) && (w == 0);
                step();
                mem_ready = 1'b0;
                restart   = 1'b0;
            end
            total_cnt++;
            if (mem_valid !== 1'b0) begin
                $display("FAIL %s_valid_drop word %0d: mem_valid=%b required 0", tag, k, mem_valid);
            end else begin
                pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || cpu_resetn !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || mem_wstrb !== 4'h0) begin
            $display("FAIL %s_done: done=%b rstn=%b busy=%b err=%b strb=%h required 1 1 0 0 0",
                     tag, done, cpu_resetn, busy, error, mem_wstrb);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    logic [31:0] rst_exp [9];
    string       out_names [9];

    task automatic test_reset();
        logic [31:0] got [9];
        snapshot(got);
        for (int i = 0; i < 9; i++) begin
            total_cnt++;
            if (got[i] !== rst_exp[i]) begin
                $display("FAIL reset_%s: got %h required %h", out_names[i], got[i], rst_exp[i]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_basic_copy();
        int dly [NW];
        int rel;
        fill_rom();
        for (int k = 0; k < NW; k++) dly[k] = 0;
        rst = 1'b0;
        rel = cyc;
        copy_words(dly, -1, "basic");
        total_cnt++;
        if (cyc - rel !== 1 + 2 * NW) begin
            $display("FAIL basic_latency: done after %0d cycles required %0d", cyc - rel, 1 + 2 * NW);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_restart_done();
        int dly [NW];
        for (int k = 0; k < NW; k++) dly[k] = 0;
        fill_rom();
        pulse_restart();
        total_cnt++;
        if (cpu_resetn !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL restart_done_exit: rstn=%b done=%b busy=%b required 0 0 1", cpu_resetn, done, busy);
        end else begin
            pass_cnt++;
        end
        copy_words(dly, -1, "rerun");
    endtask

    task automatic test_wait_states();
        int dly [NW];
        dly = '{0, 3, 0, 0};
        pulse_restart();
        copy_words(dly, -1, "wait3");
        for (int r = 0; r < 3; r++) begin
            fill_rom();
            for (int k = 0; k < NW; k++) dly[k] = $urandom_range(0, TMO - 1);
            dly[r] = TMO - 1;
            pulse_restart();
            copy_words(dly, -1, "wait_rand");
        end
    endtask

    task automatic test_restart_ignored();
        int dly [NW];
        for (int k = 0; k < NW; k++) dly[k] = $urandom_range(0, 2);
        pulse_restart();
        copy_words(dly, 2, "restart_ign");
    endtask

    task automatic test_timeout();
        int dly [NW];
        int n = 0;
        int guard = 0;
        for (int k = 0; k < NW; k++) dly[k] = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        while (mem_valid !== 1'b1 && guard < 4) begin
            step();
            guard++;
        end
        while (mem_valid === 1'b1 && n < 20) begin
            n++;
            step();
        end
        total_cnt++;
        if (n !== TMO) begin
            $display("FAIL timeout_cycles: WRITE lasted %0d cycles required %0d", n, TMO);
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (error !== 1'b1 || cpu_resetn !== 1'b0 || mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL timeout_err: err=%b rstn=%b valid=%b busy=%b done=%b required 1 0 0 0 0",
                     error, cpu_resetn, mem_valid, busy, done);
        end else begin
            pass_cnt++;
        end
        repeat (3) step();
        total_cnt++;
        if (error !== 1'b1) begin
            $display("FAIL timeout_sticky: err=%b required 1", error);
        end else begin
            pass_cnt++;
        end
        fill_rom();
        pulse_restart();
        total_cnt++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL timeout_restart: err=%b busy=%b required 0 1", error, busy);
        end else begin
            pass_cnt++;
        end
        copy_words(dly, -1, "after_err");
    endtask

    task automatic test_rst_mid_copy();
        int dly [NW];
        int guard = 0;
        logic [31:0] got [9];
        for (int k = 0; k < NW; k++) dly[k] = 0;
        fill_rom();
        pulse_restart();
        while (!(mem_valid === 1'b1 && mem_addr === exp_addr(2)) && guard < 30) begin
            mem_ready = mem_valid;
            step();
            mem_ready = 1'b0;
            guard++;
        end
        total_cnt++;
        if (mem_valid !== 1'b1 || mem_addr !== exp_addr(2)) begin
            $display("FAIL rst_mid_reach: addr=%h valid=%b required %h 1", mem_addr, mem_valid, exp_addr(2));
        end else begin
            pass_cnt++;
        end
        rst = 1'b1;
        #1;
        snapshot(got);
        for (int i = 0; i < 9; i++) begin
            total_cnt++;
            if (got[i] !== rst_exp[i]) begin
                $display("FAIL rst_mid_%s: got %h required %h", out_names[i], got[i], rst_exp[i]);
            end else begin
                pass_cnt++;
            end
        end
        step();
        rst = 1'b0;
        copy_words(dly, -1, "rst_mid_redo");
    endtask

    initial begin
        rst_exp   = '{32'(SRC), 32'h0, DBASE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        out_names = '{"rom_raddr", "mem_valid", "mem_addr", "mem_wdata", "mem_wstrb",
                      "cpu_resetn", "busy", "done", "error"};
        fill_rom();
        @(negedge clk);
        step();
        test_reset();
        test_basic_copy();
        test_restart_done();
        test_wait_states();
        test_restart_ignored();
        test_timeout();
        test_rst_mid_copy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
